// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//   Turns the PLL lock-derived reset into staged, stretched resets:
//   rst_mem releases STRETCH_CYCLES after the synchronized release, and
//   rst_core/ready follow SEQ_GAP cycles later. A rising edge on
//   sw_reset_req replays the sequence from the stretch phase.
//   Optional board button input (btn_n, debounced) is enabled by defining
//   the macro RESETSEQ_BUTTON_EN.
// ---------------------------------------------------------------------------
module reset_sequencer #(
   parameter int STRETCH_CYCLES = 1024,
   parameter int SEQ_GAP        = 256,
   parameter int DEBOUNCE_BITS  = 16
) (
   input  logic       clock,
   input  logic       reset,
`ifdef RESETSEQ_BUTTON_EN
   input  logic       btn_n,
`endif
   input  logic       sw_reset_req,
   output logic       rst_mem,
   output logic       rst_core,
   output logic       ready,
   output logic [7:0] soft_reset_cnt
);

   // Reject illegal parameter values at elaboration time.
   if (STRETCH_CYCLES < 1 || SEQ_GAP < 1 || DEBOUNCE_BITS < 1) begin : g_param_check
      $error("reset_sequencer: STRETCH_CYCLES, SEQ_GAP and DEBOUNCE_BITS must be >= 1");
   end

   localparam int MAX_CNT = (STRETCH_CYCLES > SEQ_GAP) ? STRETCH_CYCLES : SEQ_GAP;
   localparam int CNT_W   = $clog2(MAX_CNT) + 1;

   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(SEQ_GAP - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_STRETCH = 2'd1,
      ST_GAP     = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [1:0]       sync_r;
   logic             rst_sync_s;
   logic             req_prev_r;
   logic             req_edge_s;
   logic             req_s;
   logic             rst_mem_r;
   logic             rst_mem_nxt_s;
   logic             rst_core_r;
   logic             rst_core_nxt_s;
   logic             ready_r;
   logic             ready_nxt_s;
   logic [7:0]       soft_cnt_r;
   logic [7:0]       soft_cnt_nxt_s;

   // Two-flop release synchronizer: the asynchronous assert sets it, zeros shift in.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], 1'b0};
      end
   end

   assign rst_sync_s = sync_r[1];

   // Previous-cycle copy of the soft request for rising-edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         req_prev_r <= 1'b1;
      end else begin
         req_prev_r <= sw_reset_req;
      end
   end

   assign req_edge_s = sw_reset_req & ~req_prev_r;

`ifdef RESETSEQ_BUTTON_EN
   localparam logic [DEBOUNCE_BITS-1:0] DB_ONES = {DEBOUNCE_BITS{1'b1}};
   localparam logic [DEBOUNCE_BITS-1:0] DB_LAST = DB_ONES - DEBOUNCE_BITS'(1);

   logic [1:0]               btn_sync_r;
   logic [DEBOUNCE_BITS-1:0] db_cnt_r;
   logic                     btn_req_s;

   // Button synchronizer and debounce counter; the counter saturates at all-ones
   // so a held button produces only one request until it is released.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         btn_sync_r <= 2'b11;
         db_cnt_r   <= {DEBOUNCE_BITS{1'b0}};
      end else begin
         btn_sync_r <= {btn_sync_r[0], btn_n};
         if (btn_sync_r[1]) begin
            db_cnt_r <= {DEBOUNCE_BITS{1'b0}};
         end else if (db_cnt_r != DB_ONES) begin
            db_cnt_r <= db_cnt_r + DEBOUNCE_BITS'(1);
         end else begin
            db_cnt_r <= db_cnt_r;
         end
      end
   end

   // One-cycle request on the step into all-ones.
   assign btn_req_s = ~btn_sync_r[1] & (db_cnt_r == DB_LAST);
   assign req_s     = req_edge_s | btn_req_s;
`else
   assign req_s     = req_edge_s;
`endif

   // Sequencer state, counter and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= ST_SYNC;
         cnt_r      <= CNT_ZERO;
         rst_mem_r  <= 1'b1;
         rst_core_r <= 1'b1;
         ready_r    <= 1'b0;
         soft_cnt_r <= 8'd0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         rst_mem_r  <= rst_mem_nxt_s;
         rst_core_r <= rst_core_nxt_s;
         ready_r    <= ready_nxt_s;
         soft_cnt_r <= soft_cnt_nxt_s;
      end
   end

   // Next-state and next-output logic; requests are ignored while still synchronizing.
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      rst_mem_nxt_s  = rst_mem_r;
      rst_core_nxt_s = rst_core_r;
      ready_nxt_s    = ready_r;
      soft_cnt_nxt_s = soft_cnt_r;
      if (req_s && (state_r != ST_SYNC)) begin
         state_nxt_s    = ST_STRETCH;
         cnt_nxt_s      = CNT_ZERO;
         rst_mem_nxt_s  = 1'b1;
         rst_core_nxt_s = 1'b1;
         ready_nxt_s    = 1'b0;
         if (soft_cnt_r != 8'hFF) begin
            soft_cnt_nxt_s = soft_cnt_r + 8'd1;
         end else begin
            soft_cnt_nxt_s = soft_cnt_r;
         end
      end else begin
         case (state_r)
            ST_SYNC: begin
               cnt_nxt_s = CNT_ZERO;
               if (!rst_sync_s) begin
                  state_nxt_s = ST_STRETCH;
               end else begin
                  state_nxt_s = ST_SYNC;
               end
            end
            ST_STRETCH: begin
               if (cnt_r == STRETCH_LAST) begin
                  state_nxt_s   = ST_GAP;
                  cnt_nxt_s     = CNT_ZERO;
                  rst_mem_nxt_s = 1'b0;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end
            ST_GAP: begin
               if (cnt_r == GAP_LAST) begin
                  state_nxt_s    = ST_RUN;
                  cnt_nxt_s      = CNT_ZERO;
                  rst_core_nxt_s = 1'b0;
                  ready_nxt_s    = 1'b1;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end
            ST_RUN: begin
               cnt_nxt_s = CNT_ZERO;
            end
            default: begin
               state_nxt_s    = ST_SYNC;
               cnt_nxt_s      = CNT_ZERO;
               rst_mem_nxt_s  = 1'b1;
               rst_core_nxt_s = 1'b1;
               ready_nxt_s    = 1'b0;
            end
         endcase
      end
   end

   assign rst_mem        = rst_mem_r;
   assign rst_core       = rst_core_r;
   assign ready          = ready_r;
   assign soft_reset_cnt = soft_cnt_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//   Directed stimulus with a scoreboard: each stimulus step pushes the
//   output changes it should cause (cycle stamp plus output values); a
//   monitor on the falling edge pops one entry whenever the outputs change.
//   Define RESETSEQ_BUTTON_EN to include the button scenario.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

   localparam int S = 16;
   localparam int G = 4;
   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       sw_reset_req;
   logic       rst_mem;
   logic       rst_core;
   logic       ready;
   logic [7:0] soft_reset_cnt;
`ifdef RESETSEQ_BUTTON_EN
   logic       btn_n;
`endif

   int checks_total = 0;
   int checks_passed = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic [10:0] outs;   // {rst_mem, rst_core, ready, soft_reset_cnt}
   } exp_t;

   exp_t       sb_q[$];
   logic [10:0] prev_outs = {1'b1, 1'b1, 1'b0, 8'd0};
   int         exp_cnt = 0;

   reset_sequencer #(
      .STRETCH_CYCLES(S),
      .SEQ_GAP       (G),
      .DEBOUNCE_BITS (D)
   ) dut (
      .clock         (clock),
      .reset         (reset),
`ifdef RESETSEQ_BUTTON_EN
      .btn_n         (btn_n),
`endif
      .sw_reset_req  (sw_reset_req),
      .rst_mem       (rst_mem),
      .rst_core      (rst_core),
      .ready         (ready),
      .soft_reset_cnt(soft_reset_cnt)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks_total++;
      if (act == exp) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic m, input logic k, input logic r, input int n);
      exp_t e;
      e.cyc  = c;
      e.outs = {m, k, r, 8'(n)};
      sb_q.push_back(e);
   endtask

   // Release of reset after posedge p: rst_mem falls at p+3+S, rst_core/ready at p+3+S+G.
   task automatic push_release(input int p, input int n);
      push(p + 3 + S,     1'b0, 1'b1, 1'b0, n);
      push(p + 3 + S + G, 1'b0, 1'b0, 1'b1, n);
   endtask

   // Request accepted at edge t.
   task automatic push_soft(input int t, input int n);
      push(t,         1'b1, 1'b1, 1'b0, n);
      push(t + S,     1'b0, 1'b1, 1'b0, n);
      push(t + S + G, 1'b0, 1'b0, 1'b1, n);
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // One-cycle request sampled by the DUT at edge t.
   task automatic pulse_req(input int t);
      wait_until(t - 1);
      sw_reset_req = 1'b1;
      wait_until(t);
      sw_reset_req = 1'b0;
   endtask

   task automatic bump_cnt();
      if (exp_cnt < 255) exp_cnt++;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rst_mem"},  int'(rst_mem),  1);
      check({tag, "_rst_core"}, int'(rst_core), 1);
      check({tag, "_ready"},    int'(ready),    0);
      check({tag, "_cnt"},      int'(soft_reset_cnt), 0);
   endtask

   // Monitor: invariants every cycle, scoreboard pop on each output change.
   always @(negedge clock) begin
      logic [10:0] cur;
      exp_t        e;
      cur = {rst_mem, rst_core, ready, soft_reset_cnt};
      check("inv_ready_eq_not_core", int'(ready), int'(!rst_core));
      check("inv_core_implies_mem", int'(!rst_core && rst_mem), 0);
      if (cur != prev_outs) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_change", int'(cur), int'(prev_outs));
         end else begin
            e = sb_q.pop_front();
            check("sb_change_cycle", cyc, e.cyc);
            check("sb_outputs", int'(cur), int'(e.outs));
         end
      end
      prev_outs = cur;
   end

   initial begin
      int t;
      reset        = 1'b0;
      sw_reset_req = 1'b0;
`ifdef RESETSEQ_BUTTON_EN
      btn_n        = 1'b1;
`endif
      #1 reset = 1'b1;
      #2;
      check_reset_outputs("por");

      // Test 1: power-on release.
      wait_until(5);
      reset = 1'b0;
      push_release(5, 0);
      wait_until(35);

      // Test 2: 3 ns reset pulse while in RUN.
      reset = 1'b1;
      push(35, 1'b1, 1'b1, 1'b0, 0);
      #2;
      check_reset_outputs("pulse");
      #1 reset = 1'b0;
      push_release(35, 0);
      exp_cnt = 0;
      wait_until(63);

      // Test 3: single soft request from RUN.
      bump_cnt();
      push_soft(65, exp_cnt);
      pulse_req(65);
      wait_until(90);
      check("t3_cnt", int'(soft_reset_cnt), 1);

      // Test 4: request from RUN, then another two cycles into GAP.
      bump_cnt();
      push(95,     1'b1, 1'b1, 1'b0, exp_cnt);
      push(95 + S, 1'b0, 1'b1, 1'b0, exp_cnt);
      bump_cnt();
      push_soft(95 + S + 2, exp_cnt);
      pulse_req(95);
      pulse_req(95 + S + 2);
      wait_until(135);
      check("t4_cnt", int'(soft_reset_cnt), 3);

      // Test 5a: request held high for 100 cycles -> one sequence.
      bump_cnt();
      push_soft(140, exp_cnt);
      wait_until(139);
      sw_reset_req = 1'b1;
      wait_until(239);
      sw_reset_req = 1'b0;
      wait_until(245);
      check("t5_held_cnt", int'(soft_reset_cnt), 4);

      // Test 5b: 300 spaced pulses saturate the counter.
      for (int i = 0; i < 300; i++) begin
         t = 250 + i * 30;
         bump_cnt();
         push_soft(t, exp_cnt);
         pulse_req(t);
      end
      wait_until(250 + 299 * 30 + 25);
      check("t5_sat_cnt", int'(soft_reset_cnt), 255);

`ifdef RESETSEQ_BUTTON_EN
      // Test 6: clear the count with a reset pulse, then exercise the button.
      wait_until(9250);
      reset = 1'b1;
      push(9250, 1'b1, 1'b1, 1'b0, 0);
      #3 reset = 1'b0;
      push_release(9250, 0);
      exp_cnt = 0;
      wait_until(9280);
      btn_n = 1'b0;
      wait_until(9290);
      btn_n = 1'b1;
      wait_until(9305);
      check("t6_short_press_cnt", int'(soft_reset_cnt), 0);
      bump_cnt();
      push_soft(9310 + 17, exp_cnt);
      wait_until(9310);
      btn_n = 1'b0;
      wait_until(9330);
      btn_n = 1'b1;
      bump_cnt();
      push_soft(9350 + 17, exp_cnt);
      wait_until(9350);
      btn_n = 1'b0;
      wait_until(9370);
      btn_n = 1'b1;
      wait_until(9395);
      check("t6_button_cnt", int'(soft_reset_cnt), 2);
`endif

      wait_until(cyc + 5);
      check("sb_queue_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
